ps2_fifo_rf: RTL
================

# ps2_fifo_rf

Memory-mapped PS/2 keyboard register file with a parametrised receive FIFO. It sits between the PS/2 scan-code decoder and the CPU bus. It buffers up to DEPTH scan codes instead of a single data byte. It adds interrupt enable, sticky pending and overflow status, occupancy reporting, and read-to-pop data access.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- DATA_W, 8, scan-code width; ≤24.
- CW, $clog2(DEPTH+1), count field width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  bus write strobe.
- re  in  1  bus read strobe; qualifies pop side effects.
- addr  in  4  byte address; addr[3:2] selects the register; addr[1:0] is ignored.
- wd  in  32  write data.
- rd  out  32  read data, combinational from addr.
- byte_vld  in  1  one-cycle pulse: ps2_byte is valid.
- ps2_byte  in  DATA_W  received scan code.
- caps_flg  in  1  caps-lock state from the decoder.
- intr  out  1  interrupt request, level.
- caps  out  1  registered caps_flg.

## Operation
- 0x0 CTRL (R/W):
  - bit0 IE.
  - bit1 FLUSH: write-1, self-clearing, always reads 0.
- 0x4 STAT:
  - bit0 PEND: sticky, set on every accepted push, W1C.
  - bit1 OVF: sticky, set on a dropped push, W1C.
  - bit2 FULL, bit3 EMPTY: read-only.
  - bits[8+CW-1:8] COUNT: read-only.
  - All other bits read 0.
- 0x8 DATA: rd = {0, head entry}, or 0 when empty.
  - re && addr==0x8 pops one entry if not empty.
  - Writes to DATA are ignored.
- 0xC FLAG: bit0 caps; read-only.
- intr = CTRL.IE & (STAT.PEND | STAT.OVF). It is driven from registers only.
- Push rules (byte_vld=1):
  - Not full: write at the tail, COUNT+1, PEND set.
  - Full and no pop this cycle: byte dropped, OVF set, FIFO unchanged.
  - Full with a pop the same cycle: push accepted, COUNT unchanged, PEND set.
- Pop on empty: no effect, no error flag.
- FLUSH: pointers and COUNT go to 0 at the next edge. A same-cycle push is discarded with no OVF. PEND and OVF are not cleared.
- Set beats W1C: if PEND/OVF are set and cleared in the same cycle, the flag stays 1.
- Pointers wrap modulo DEPTH. COUNT ranges 0..DEPTH and never wraps.
- Reset values:
  - CTRL=0, PEND=0, OVF=0, pointers=0, COUNT=0, caps=0.
  - rd reflects empty state: STAT reads 0x8.
  - intr=0.

## Timing
- Push at edge N: the byte is readable at DATA and COUNT is updated after edge N. PEND, and intr if IE=1, assert after the same edge.
- Pop: rd shows the current head during the read cycle. The next entry appears after the edge.
- A CTRL write takes effect after the edge. intr follows IE with no extra delay.
- caps follows caps_flg with one cycle of latency.
- Reset mid-operation clears all state asynchronously. Queued bytes are lost.

## Structure
- Shared package ps2_pkg:
  - register offset constants (CTRL/STAT/DATA/FLAG);
  - STAT bit positions;
  - CTRL bit positions.
- Sub-module ps2_rx_fifo (DEPTH, DATA_W):
  - synchronous FIFO with push/pop/flush, head, count, full, empty;
  - the simultaneous push+pop-when-full rule lives here.
- The top level holds the CTRL/STAT/FLAG registers, the address decode, the rd mux and intr.

## Test plan
- Reset, then read all four registers: CTRL=0, STAT=0x8, DATA=0, FLAG=0; intr=0, caps=0.
- IE=1; push 0x1C, 0x32, 0x21 -> STAT COUNT=3, PEND=1, intr=1 one cycle after the first push. Three DATA pops -> 0x1C, 0x32, 0x21 in order, then EMPTY=1. W1C PEND -> intr=0.
- DEPTH=8: push 9 bytes 0x01..0x09 -> FULL=1, COUNT=8, OVF=1. Popping 8 returns 0x01..0x08; 0x09 is absent.
- Full FIFO, byte_vld with a DATA pop in the same cycle (byte 0x55) -> pop returns the oldest byte, COUNT stays 8, OVF unchanged, 0x55 appears last.
- Write FLUSH with 5 entries and a same-cycle push -> COUNT=0, EMPTY=1, OVF=0, PEND retained, CTRL bit1 reads 0.
- Assert rst_n low mid-stream with 4 entries queued -> all outputs at reset values immediately. After release, a pop on empty reads 0 and leaves COUNT=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard register file: register offsets,
// register-select decode and bit positions inside CTRL, STAT and FLAG.
package ps2_pkg;

    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_STAT = 4'h4;
    localparam logic [3:0] OFF_DATA = 4'h8;
    localparam logic [3:0] OFF_FLAG = 4'hC;

    typedef enum logic [1:0] {
        REG_CTRL = OFF_CTRL[3:2],
        REG_STAT = OFF_STAT[3:2],
        REG_DATA = OFF_DATA[3:2],
        REG_FLAG = OFF_FLAG[3:2]
    } reg_sel_e;

    localparam int CTRL_IE    = 0;
    localparam int CTRL_FLUSH = 1;

    localparam int STAT_PEND  = 0;
    localparam int STAT_OVF   = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_EMPTY = 3;
    localparam int STAT_COUNT = 8;

    localparam int FLAG_CAPS  = 0;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Receive FIFO for scan codes with push/pop/flush; a push into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise it is dropped.
module ps2_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              push_acc,
    output logic              push_drop
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_s, empty_s, pop_s, acc_s, drop_s;

    // Occupancy flags, push/pop qualification and next pointer/count values.
    always_comb begin
        full_s   = (count_q == CW'(DEPTH));
        empty_s  = (count_q == {CW{1'b0}});
        pop_s    = pop & ~empty_s & ~flush;
        acc_s    = push & ~flush & (~full_s | pop_s);
        drop_s   = push & ~flush & full_s & ~pop_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (acc_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({acc_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: {DATA_W{1'b0}}};
        end else if (acc_s) begin
            mem_q[wr_ptr_q] <= din;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = full_s;
    assign empty     = empty_s;
    assign push_acc  = acc_s;
    assign push_drop = drop_s;

endmodule

// File: rtl/ps2_fifo_rf.sv
// Memory-mapped PS/2 keyboard register file: CTRL/STAT/DATA/FLAG registers in
// front of a scan-code receive FIFO, with a level interrupt request.
module ps2_fifo_rf
    import ps2_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [3:0]        addr,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    input  logic              byte_vld,
    input  logic [DATA_W-1:0] ps2_byte,
    input  logic              caps_flg,
    output logic              intr,
    output logic              caps
);

    reg_sel_e          sel_s;
    logic              ie_q, ie_d, pend_q, pend_d, ovf_q, ovf_d;
    logic              intr_q, intr_d, caps_q, caps_d;
    logic              flush_s, pop_s, stat_wr_s;
    logic [DATA_W-1:0] head_s;
    logic [CW-1:0]     count_s;
    logic              full_s, empty_s, push_acc_s, push_drop_s;
    logic              unused_s;

    assign sel_s     = reg_sel_e'(addr[3:2]);
    assign flush_s   = we & (sel_s == REG_CTRL) & wd[CTRL_FLUSH];
    assign stat_wr_s = we & (sel_s == REG_STAT);
    assign pop_s     = re & (sel_s == REG_DATA);
    assign unused_s  = ^{wd[31:2], addr[1:0]};

    ps2_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CW(CW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (byte_vld),
        .din       (ps2_byte),
        .pop       (pop_s),
        .flush     (flush_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s),
        .push_acc  (push_acc_s),
        .push_drop (push_drop_s)
    );

    // Next register values; a set from the FIFO overrides a same-cycle W1C.
    always_comb begin
        if (we && (sel_s == REG_CTRL)) begin
            ie_d = wd[CTRL_IE];
        end else begin
            ie_d = ie_q;
        end
        pend_d = push_acc_s  | (pend_q & ~(stat_wr_s & wd[STAT_PEND]));
        ovf_d  = push_drop_s | (ovf_q  & ~(stat_wr_s & wd[STAT_OVF]));
        intr_d = ie_d & (pend_d | ovf_d);
        caps_d = caps_flg;
    end

    // Control/status flags and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_q   <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            intr_q <= 1'b0;
            caps_q <= 1'b0;
        end else begin
            ie_q   <= ie_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            intr_q <= intr_d;
            caps_q <= caps_d;
        end
    end

    // Read-data mux, decoded from addr alone.
    always_comb begin
        rd = 32'd0;
        case (sel_s)
            REG_CTRL: rd[CTRL_IE] = ie_q;
            REG_STAT: begin
                rd[STAT_PEND]          = pend_q;
                rd[STAT_OVF]           = ovf_q;
                rd[STAT_FULL]          = full_s;
                rd[STAT_EMPTY]         = empty_s;
                rd[STAT_COUNT +: CW]   = count_s;
            end
            REG_DATA: begin
                if (empty_s) begin
                    rd = 32'd0;
                end else begin
                    rd[DATA_W-1:0] = head_s;
                end
            end
            REG_FLAG: rd[FLAG_CAPS] = caps_q;
            default:  rd = 32'd0;
        endcase
    end

    assign intr = intr_q;
    assign caps = caps_q;

endmodule
